// File: rtl/nco_freq_config.sv
// Runtime-programmable NCO clock-enable generator: converts a requested output
// frequency into a 20-bit phase increment with a serial restoring divider.
module nco_freq_config #(
  parameter logic [31:0] INPUT_FREQ = 32'd50_000_000,
  parameter logic [31:0] RESET_FREQ = 32'd25_175_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_freq,
  output logic        req_ready,
  output logic        done,
  output logic        err,
  output logic [19:0] cur_inc,
  output logic        enable
);

  localparam logic [63:0] RESET_INC_W = ({32'd0, RESET_FREQ} << 20) / {32'd0, INPUT_FREQ};
  localparam logic [19:0] RESET_INC   = RESET_INC_W[19:0];

  typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [32:0] rem;
  logic [19:0] q;
  logic [4:0]  cnt;
  logic [19:0] acc;
  logic        accept;
  logic        reject;
  logic [33:0] step;

  // One restoring-division iteration: {quotient bit, next remainder}.
  // rem < INPUT_FREQ < 2^32, so the doubled value always fits in 33 bits.
  function automatic logic [33:0] div_step(input logic [32:0] r);
    logic [32:0] t;
    t = r << 1;
    if (t >= {1'b0, INPUT_FREQ})
      return {1'b1, t - {1'b0, INPUT_FREQ}};
    else
      return {1'b0, t};
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign reject    = accept && (req_freq >= INPUT_FREQ);
  assign step      = div_step(rem);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !reject) state_nxt = DIV;
      DIV:     if (cnt == 5'd0)       state_nxt = LOAD;
      LOAD:                           state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Control and accumulator: the accumulator free-runs through division so the
  // new increment takes over without a phase discontinuity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      cur_inc <= RESET_INC;
      done    <= 1'b0;
      err     <= 1'b0;
      acc     <= 20'd0;
      enable  <= 1'b0;
    end else begin
      state         <= state_nxt;
      done          <= (state == LOAD);
      err           <= reject;
      {enable, acc} <= {1'b0, acc} + {1'b0, cur_inc};
      if (state == IDLE && accept)
        cnt <= 5'd19;
      else if (state == DIV)
        cnt <= cnt - 5'd1;
      if (state == LOAD)
        cur_inc <= q;
    end
  end

  // Divider datapath: only meaningful while in DIV, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      rem <= {1'b0, req_freq};
      q   <= 20'd0;
    end else if (state == DIV) begin
      rem <= step[32:0];
      q   <= {q[18:0], step[33]};
    end
  end

endmodule
